// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared encodings for the AXI read-channel arbiter.
// Used with the optional AXI_RD_ARB_RR_EN build macro (see axi_rd_arb_sel).
package axi_rd_arbiter_pkg;

    // Cache-side read request types
    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    localparam logic [3:0] IC_ID_DEF = 4'd0;
    localparam logic [3:0] DC_ID_DEF = 4'd1;

    // Line refills move whole words; single loads use the size bits of the type.
    function automatic logic [2:0] ar_size_of(input logic [2:0] rd_type);
        return (rd_type == RD_LINE) ? AXI_SIZE_WORD : {1'b0, rd_type[1:0]};
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: cache request/return ports plus the shared AXI AR/R channel.
// master = arbiter view, slave = caches and AXI slave view.
interface axi_rd_arbiter_if;
    logic        ic_rd_req;
    logic [2:0]  ic_rd_type;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_rdy;
    logic        ic_ret_valid;
    logic        ic_ret_last;
    logic [31:0] ic_ret_data;

    logic        dc_rd_req;
    logic [2:0]  dc_rd_type;
    logic [31:0] dc_rd_addr;
    logic        dc_rd_rdy;
    logic        dc_ret_valid;
    logic        dc_ret_last;
    logic [31:0] dc_ret_data;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        rd_err;

    modport master (
        input  ic_rd_req, ic_rd_type, ic_rd_addr,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  dc_rd_req, dc_rd_type, dc_rd_addr,
        output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output rd_err
    );

    modport slave (
        output ic_rd_req, ic_rd_type, ic_rd_addr,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output dc_rd_req, dc_rd_type, dc_rd_addr,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  rd_err
    );
endinterface

// File: rtl/axi_rd_arb_sel.sv
// axi_rd_arb_sel: two-requester grant logic for the read arbiter.
// Default: dc has fixed priority over ic.
// AXI_RD_ARB_RR_EN: round-robin, the requester not granted last wins on contention.
module axi_rd_arb_sel (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic idle_i,
    input  logic ic_req_i,
    input  logic dc_req_i,
    output logic sel_dc_o,
    output logic ic_rdy_o,
    output logic dc_rdy_o
);
    logic last_dc_q;
    logic last_dc_d;
    logic sel_dc;

`ifdef AXI_RD_ARB_RR_EN
    assign sel_dc = dc_req_i & (~ic_req_i | ~last_dc_q);
`else
    logic unused_last_dc;
    assign unused_last_dc = last_dc_q;
    assign sel_dc = dc_req_i;
`endif

    assign sel_dc_o = sel_dc;
    assign ic_rdy_o = idle_i & ic_req_i & ~sel_dc;
    assign dc_rdy_o = idle_i & sel_dc;

    // Any request seen in IDLE is granted that cycle, so record who won.
    assign last_dc_d = (idle_i & (ic_req_i | dc_req_i)) ? sel_dc : last_dc_q;

    // Last-granted register; reset favours dc on the first contention.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_dc_q <= 1'b0;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between icache and dcache.
// One outstanding read; R beats pass straight through to the granted port.
// Optional macro AXI_RD_ARB_RR_EN: round-robin grant and rid checking.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] IC_ID      = IC_ID_DEF,
    parameter logic [3:0] DC_ID      = DC_ID_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_rd_arbiter_if.master bus
);
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    arb_state_e  state_q;
    logic        gnt_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;

    logic        idle;
    logic        sel_dc;
    logic        ic_rdy;
    logic        dc_rdy;
    logic        accept;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic        beat_ok;
    logic        rid_bad;

    assign idle = (state_q == ST_IDLE);

    axi_rd_arb_sel u_sel (
        .clk_i    (aclk),
        .rst_n_i  (aresetn),
        .idle_i   (idle),
        .ic_req_i (bus.ic_rd_req),
        .dc_req_i (bus.dc_rd_req),
        .sel_dc_o (sel_dc),
        .ic_rdy_o (ic_rdy),
        .dc_rdy_o (dc_rdy)
    );

    // dc_rdy already implies dc_rd_req
    assign accept   = (ic_rdy & bus.ic_rd_req) | dc_rdy;
    assign req_type = sel_dc ? bus.dc_rd_type : bus.ic_rd_type;
    assign req_addr = sel_dc ? bus.dc_rd_addr : bus.ic_rd_addr;

    // Request/address/data sequencing with registered AR fields and rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            arid_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arsize_q  <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q     <= sel_dc;
                        arid_q    <= sel_dc ? DC_ID : IC_ID;
                        araddr_q  <= req_addr;
                        arlen_q   <= (req_type == RD_LINE) ? LINE_LEN : 8'd0;
                        arsize_q  <= ar_size_of(req_type);
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.rvalid && bus.rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ic_rd_rdy = ic_rdy;
    assign bus.dc_rd_rdy = dc_rdy;

    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arsize  = arsize_q;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    // rready is only high in DATA, so an accepted beat is rready & rvalid.
    assign beat_ok = rready_q & bus.rvalid;

    assign bus.ic_ret_valid = beat_ok & ~gnt_q;
    assign bus.ic_ret_last  = beat_ok & ~gnt_q & bus.rlast;
    assign bus.ic_ret_data  = bus.rdata;
    assign bus.dc_ret_valid = beat_ok & gnt_q;
    assign bus.dc_ret_last  = beat_ok & gnt_q & bus.rlast;
    assign bus.dc_ret_data  = bus.rdata;

`ifdef AXI_RD_ARB_RR_EN
    assign rid_bad = beat_ok & (bus.rid != arid_q);
`else
    logic unused_rid;
    assign unused_rid = ^bus.rid;
    assign rid_bad = 1'b0;
`endif

    assign bus.rd_err = (beat_ok & (bus.rresp != 2'b00)) | rid_bad;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized checks of the read arbiter
// against a transaction-level model of grant rules and AR/R behaviour.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int LW = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(.LINE_WORDS(LW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit last_dc = 1'b0;      // model: who was granted last
    int err_beat = -1;       // beat index that returns SLVERR, -1 none
    int err_seen = 0;
    int beats_seen = 0;
    bit pat_q[$];            // forced rvalid pattern, random once empty
    logic [2:0] types [4] = '{RD_BYTE, RD_HALF, RD_WORD, RD_LINE};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_inputs();
        bus.ic_rd_req = 0; bus.ic_rd_type = 0; bus.ic_rd_addr = 0;
        bus.dc_rd_req = 0; bus.dc_rd_type = 0; bus.dc_rd_addr = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0;
        bus.rlast = 0; bus.rvalid = 0;
    endtask

    function automatic bit model_winner();
        if (bus.dc_rd_req && !bus.ic_rd_req) return 1'b1;
        if (bus.ic_rd_req && !bus.dc_rd_req) return 1'b0;
`ifdef AXI_RD_ARB_RR_EN
        return !last_dc;
`else
        return 1'b1;
`endif
    endfunction

    // One complete transaction from IDLE; abort_after >= 0 returns in DATA after that many beats.
    task automatic do_txn(input int ar_delay, input int abort_after);
        bit w_dc, v;
        logic [2:0] t;
        logic [31:0] a;
        logic [7:0] e_len;
        logic [2:0] e_size;
        logic [3:0] e_id;
        logic [52:0] act_ar, exp_ar;
        logic [36:0] act_b, exp_b;
        int n, cyc;
        beats_seen = 0;
        err_seen = 0;
        #1;
        if (!bus.ic_rd_req && !bus.dc_rd_req) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_setup: no requester active");
            return;
        end
        w_dc = model_winner();
        n_cmp++;
        if ({bus.ic_rd_rdy, bus.dc_rd_rdy} !== {!w_dc, w_dc}) begin
            n_bad++;
            $display("FAIL grant_rdy: got ic/dc rdy=%b%b want %b%b",
                     bus.ic_rd_rdy, bus.dc_rd_rdy, !w_dc, w_dc);
        end
        t = w_dc ? bus.dc_rd_type : bus.ic_rd_type;
        a = w_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
        e_len  = (t == RD_LINE) ? 8'(LW - 1) : 8'd0;
        e_size = (t == RD_LINE) ? 3'd2 : {1'b0, t[1:0]};
        e_id   = w_dc ? 4'd1 : 4'd0;
        n = int'(e_len) + 1;
        last_dc = w_dc;
        @(posedge aclk); #1;
        if (w_dc) bus.dc_rd_req = 0; else bus.ic_rd_req = 0;
        for (int i = 0; i <= ar_delay; i++) begin
            bus.arready = (i == ar_delay);
            #1;
            act_ar = {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize,
                      bus.arburst, bus.rready, bus.ic_rd_rdy, bus.dc_rd_rdy};
            exp_ar = {1'b1, e_id, a, e_len, e_size, 2'b01, 1'b0, 2'b00};
            n_cmp++;
            if (act_ar !== exp_ar) begin
                n_bad++;
                $display("FAIL ar_fields cyc%0d: got %h want %h", i, act_ar, exp_ar);
            end
            @(posedge aclk); #1;
        end
        bus.arready = 0;
        #1;
        n_cmp++;
        if ({bus.arvalid, bus.rready} !== 2'b01) begin
            n_bad++;
            $display("FAIL data_entry: got arvalid/rready=%b%b want 01", bus.arvalid, bus.rready);
        end
        cyc = 0;
        while (beats_seen < n && cyc < 200) begin
            if (abort_after >= 0 && beats_seen == abort_after) return;
            v = (pat_q.size() > 0) ? pat_q.pop_front() : ($urandom_range(3) != 0);
            bus.rvalid = v;
            bus.rdata  = $urandom;
            bus.rlast  = v && (beats_seen == n - 1);
            bus.rresp  = (v && beats_seen == err_beat) ? 2'b10 : 2'b00;
            bus.rid    = e_id;
            #1;
            if (bus.rd_err === 1'b1) err_seen++;
            if (w_dc) act_b = {bus.dc_ret_valid, bus.dc_ret_last, bus.dc_ret_data, bus.ic_ret_valid, bus.rd_err};
            else      act_b = {bus.ic_ret_valid, bus.ic_ret_last, bus.ic_ret_data, bus.dc_ret_valid, bus.rd_err};
            exp_b = {v, bus.rlast, bus.rdata, 1'b0, (bus.rresp != 2'b00)};
            if (!v) begin
                act_b[34:3] = 32'd0;
                exp_b[34:3] = 32'd0;
            end
            n_cmp++;
            if (act_b !== exp_b) begin
                n_bad++;
                $display("FAIL ret_beat%0d cyc%0d: got %h want %h", beats_seen, cyc, act_b, exp_b);
            end
            if (v) beats_seen++;
            cyc++;
            @(posedge aclk); #1;
        end
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
        if (cyc >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL data_timeout: beats %0d want %0d", beats_seen, n);
        end
        #1;
        n_cmp++;
        if ({bus.arvalid, bus.rready} !== 2'b00) begin
            n_bad++;
            $display("FAIL back_to_idle: got arvalid/rready=%b%b want 00", bus.arvalid, bus.rready);
        end
    endtask

    task automatic check_reset_values(input string tag);
        logic [55:0] act, exp_v;
        act = {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst,
               bus.rready, bus.ic_ret_valid, bus.ic_ret_last, bus.dc_ret_valid,
               bus.dc_ret_last, bus.rd_err};
        exp_v = {1'b0, 4'd0, 32'd0, 8'd0, 3'd0, 2'b01, 6'b0};
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp_v);
        end
    endtask

    task automatic test_reset();
        init_inputs();
        aresetn = 0;
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values("reset_values");
        aresetn = 1; last_dc = 0;
        @(posedge aclk); #1;
        n_cmp++;
        if ({bus.ic_rd_rdy, bus.dc_rd_rdy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_req_rdy: got %b%b want 00", bus.ic_rd_rdy, bus.dc_rd_rdy);
        end
        bus.dc_rd_req = 1;
        #1;
        n_cmp++;
        if ({bus.ic_rd_rdy, bus.dc_rd_rdy} !== 2'b01) begin
            n_bad++;
            $display("FAIL idle_dc_only_rdy: got %b%b want 01", bus.ic_rd_rdy, bus.dc_rd_rdy);
        end
        bus.dc_rd_req = 0;
        @(posedge aclk); #1;
    endtask

    task automatic test_ic_line();
        bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = 32'h1c00_0000; bus.ic_rd_req = 1;
        do_txn(3, -1);
        n_cmp++;
        if (beats_seen != LW) begin
            n_bad++;
            $display("FAIL ic_line_beats: got %0d want %0d", beats_seen, LW);
        end
    endtask

    task automatic test_contention();
        bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = $urandom & 32'hffff_fff0; bus.ic_rd_req = 1;
        bus.dc_rd_type = RD_WORD; bus.dc_rd_addr = $urandom & 32'hffff_fffc; bus.dc_rd_req = 1;
        do_txn($urandom_range(2), -1);
        bus.dc_rd_type = RD_LINE; bus.dc_rd_addr = $urandom & 32'hffff_fff0; bus.dc_rd_req = 1;
        do_txn($urandom_range(2), -1);
        do_txn($urandom_range(2), -1);
        n_cmp++;
        if ({bus.ic_rd_req, bus.dc_rd_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL contention_drain: pending ic/dc=%b%b want 00", bus.ic_rd_req, bus.dc_rd_req);
        end
    endtask

    task automatic test_dc_byte();
        bus.dc_rd_type = RD_BYTE; bus.dc_rd_addr = 32'hbfaf_8003; bus.dc_rd_req = 1;
        do_txn($urandom_range(3), -1);
        n_cmp++;
        if (beats_seen != 1) begin
            n_bad++;
            $display("FAIL dc_byte_beats: got %0d want 1", beats_seen);
        end
    endtask

    task automatic test_error();
        err_beat = 1;
        bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = 32'h0000_1240; bus.ic_rd_req = 1;
        do_txn(0, -1);
        err_beat = -1;
        n_cmp++;
        if (err_seen != 1 || beats_seen != LW) begin
            n_bad++;
            $display("FAIL err_resp: got pulses=%0d beats=%0d want 1 %0d", err_seen, beats_seen, LW);
        end
    endtask

    task automatic test_backpressure();
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.dc_rd_type = RD_LINE; bus.dc_rd_addr = 32'h8000_0100; bus.dc_rd_req = 1;
        do_txn(1, -1);
        n_cmp++;
        if (beats_seen != LW || pat_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_beats: got beats=%0d left=%0d want %0d 0", beats_seen, pat_q.size(), LW);
        end
        bus.rvalid = 1; bus.rlast = 1; bus.rresp = 2'b10;
        #1;
        n_cmp++;
        if ({bus.ic_ret_valid, bus.dc_ret_valid, bus.rd_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_stray_beat: got %b%b%b want 000",
                     bus.ic_ret_valid, bus.dc_ret_valid, bus.rd_err);
        end
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
        @(posedge aclk); #1;
    endtask

    task automatic test_reset_mid();
        pat_q = '{1'b1, 1'b1};
        bus.ic_rd_type = RD_LINE; bus.ic_rd_addr = 32'h1c00_0040; bus.ic_rd_req = 1;
        do_txn(1, 2);
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
        #1 aresetn = 0;
        #1;
        check_reset_values("reset_mid_data");
        @(posedge aclk); #1;
        aresetn = 1; last_dc = 0;
        @(posedge aclk); #1;
        bus.ic_rd_type = RD_WORD; bus.ic_rd_addr = 32'h1c00_0084; bus.ic_rd_req = 1;
        do_txn(0, -1);
        n_cmp++;
        if (beats_seen != 1) begin
            n_bad++;
            $display("FAIL after_reset_beats: got %0d want 1", beats_seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            if (!bus.ic_rd_req && $urandom_range(1) == 1) begin
                bus.ic_rd_type = types[$urandom_range(3)]; bus.ic_rd_addr = $urandom; bus.ic_rd_req = 1;
            end
            if (!bus.dc_rd_req && $urandom_range(1) == 1) begin
                bus.dc_rd_type = types[$urandom_range(3)]; bus.dc_rd_addr = $urandom; bus.dc_rd_req = 1;
            end
            if (!bus.ic_rd_req && !bus.dc_rd_req) begin
                bus.ic_rd_type = types[$urandom_range(3)]; bus.ic_rd_addr = $urandom; bus.ic_rd_req = 1;
            end
            err_beat = ($urandom_range(9) < 3) ? int'($urandom_range(LW - 1)) : -1;
            do_txn($urandom_range(3), -1);
        end
        err_beat = -1;
        while (bus.ic_rd_req || bus.dc_rd_req) do_txn($urandom_range(2), -1);
    endtask

    initial begin
        test_reset();
        test_ic_line();
        test_contention();
        test_dc_byte();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of core_top between the icache refill port and the dcache refill/uncached-load port.
- Grants one requester at a time and supports one outstanding AXI read.
- Converts the cache-side rd_req/rd_type/rd_addr interface into AXI AR beats and routes R beats back as ret_valid/ret_last/ret_data.
- Sits between the icache/dcache and the core_top AXI pins.

Parameters:
- LINE_WORDS, 4, words per cache-line refill burst (power of 2, 2..16).
- IC_ID, 4'd0, arid used for icache transactions.
- DC_ID, 4'd1, arid used for dcache transactions.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  3  000 byte, 001 half, 010 word, 100 line
- ic_rd_addr  in  32  request address
- ic_rd_rdy  out  1  request accepted this cycle when high with ic_rd_req
- ic_ret_valid  out  1  return beat valid
- ic_ret_last  out  1  final return beat
- ic_ret_data  out  32  return data
- dc_rd_req, dc_rd_type, dc_rd_addr, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data  same as the ic_ group, for the dcache
- arid  out  4; araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1
- rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- rd_err  out  1  one-cycle pulse when a beat returns rresp != 0

Behaviour:
- FSM states: IDLE, ADDR, DATA. Register `gnt` (0 = ic, 1 = dc).
- IDLE:
  - Arbitrate combinationally among requesters whose rd_req is high. Fixed priority: dc over ic.
  - Assert the winner's rd_rdy only; the loser's rd_rdy stays 0.
  - On rd_req & rd_rdy, latch addr/type and gnt, then go to ADDR next cycle.
  - rd_rdy is 0 in every other state.
- ADDR:
  - arvalid = 1. All AR fields are registered and held stable until arready.
  - arid = IC_ID or DC_ID; araddr = latched address.
  - Line request: arlen = LINE_WORDS-1, arsize = 3'b010.
  - Single request: arlen = 0, arsize = {1'b0, type[1:0]}.
  - arburst = 2'b01 (INCR).
  - arvalid & arready -> DATA. arvalid drops the next cycle.
- DATA:
  - rready = 1.
  - Granted port: ret_valid = rvalid, ret_data = rdata, ret_last = rlast (combinational pass-through, zero added latency).
  - Non-granted port: ret_valid = 0.
  - rvalid & rlast -> IDLE.
  - The beat counter is informational only; completion is defined solely by rlast.
- rid is not used for routing. It is compared against the granted id only under the optional feature.
- rresp != 0 on an accepted beat: rd_err pulses for 1 cycle. Data is still forwarded and the burst still completes.
- Minimum occupancy: 1 cycle IDLE + 1 cycle ADDR + N beats. A new request is accepted in the first IDLE cycle after rlast; there is no back-to-back bypass.
- Simultaneous ic and dc requests: dc wins; the ic request stays pending (ic must hold req/addr/type until rd_rdy).
- Reset values (async, aresetn low):
  - state = IDLE; arvalid, rready, all ret_valid, ret_last and rd_err = 0.
  - araddr, arlen, arsize, arid = 0; arburst = 2'b01.
  - rd_rdy follows the IDLE arbitration once reset is released.
- Reset mid-transaction: immediate return to IDLE with arvalid and rready = 0. The AXI slave is reset on the same aresetn.
- Unused AXI signals (arlock, arcache, arprot) are tied off in core_top, not here.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined: round-robin arbitration. A last-granted register gives priority to the other requester on contention.
- Undefined: fixed dc-over-ic priority as specified above.
- In both cases the ret_valid, ret_last and ret_data routing is identical.

Decomposition:
- Shared package holds:
  - rd_type encodings (RD_BYTE, RD_HALF, RD_WORD, RD_LINE).
  - FSM state encodings.
  - AXI burst/size constants.
  - IC_ID/DC_ID defaults.
- One natural sub-module: axi_rd_arb_sel, the two-requester grant logic (fixed or round-robin). It is combinational apart from the last-granted register.

Test Plan:
- Single requester: ic line read at 0x1c000000 with arready delayed 3 cycles -> arvalid held 3 cycles; arlen = 3, arsize = 2, arid = 0; 4 beats reach the ic port with ret_last on beat 4; dc_ret_valid stays 0.
- Contention: ic and dc both request in the same IDLE cycle -> dc_rd_rdy = 1, ic_rd_rdy = 0. ic is accepted in the first IDLE cycle after the dc rlast (with AXI_RD_ARB_RR_EN, a second contention cycle grants ic).
- Uncached byte load: dc type 000 at 0xbfaf8003 -> arlen = 0, arsize = 0, araddr = 0xbfaf8003; one beat returned with ret_last = 1.
- Error response: rresp = 2'b10 on beat 2 of 4 -> rd_err pulses once; all 4 beats are still delivered and the FSM returns to IDLE.
- R backpressure gaps: rvalid toggles 1,0,0,1,1,0,1 -> ret_valid mirrors rvalid exactly; no extra or duplicate beats.
- Reset asserted during DATA after 2 beats -> outputs reach reset values asynchronously; after release, a new ic request is accepted in IDLE.
